// File: rtl/uart_tx_queue_pkg.sv
// +----------------------------------------------------------------------+
// | uart_txq_pkg: status-word bit positions and default queue depth       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package uart_txq_pkg;

  localparam int DEFAULT_DEPTH = 16;

  // Shared with the SOC IO decode and the firmware header
  localparam int STAT_FULL_BIT = 9;
  localparam int STAT_IDLE_BIT = 10;
  localparam int STAT_OVF_BIT  = 11;

  function automatic logic [31:0] make_status(input logic full,
                                              input logic idle,
                                              input logic ovf);
    logic [31:0] w_word;
    w_word                = '0;
    w_word[STAT_FULL_BIT] = full;
    w_word[STAT_IDLE_BIT] = idle;
    w_word[STAT_OVF_BIT]  = ovf;
    return w_word;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_queue_if.sv
// +----------------------------------------------------------------------+
// | uart_tx_queue_if: CPU write side, emitter handshake and status lines  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

interface uart_tx_queue_if
  import uart_txq_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int LW    = $clog2(DEPTH) + 1
) ();

  logic          wr_valid;
  logic [7:0]    wr_data;
  logic          flush;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_ready;
  logic          full;
  logic [LW-1:0] level;
  logic          overflow;
  logic [31:0]   status;

  modport master (
    output wr_valid, wr_data, flush, tx_ready,
    input  tx_valid, tx_data, full, level, overflow, status
  );

  modport slave (
    input  wr_valid, wr_data, flush, tx_ready,
    output tx_valid, tx_data, full, level, overflow, status
  );

endinterface

`default_nettype wire

// File: rtl/sync_fifo.sv
// +----------------------------------------------------------------------+
// | sync_fifo: generic circular buffer with flush, level and full/empty   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  wire logic             clk,
  input  wire logic             resetn,
  input  wire logic             push,
  input  wire logic             pop,
  input  wire logic             flush,
  input  wire logic [WIDTH-1:0] din,
  output logic      [WIDTH-1:0] dout,
  output logic      [LW-1:0]    level,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [LW-1:0]    r_level;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // A push on a full queue lands in the slot being popped this same edge
  always_ff @(posedge clk) begin
    if (push && !flush) r_mem[r_wr_ptr] <= din;
  end

  assign level = r_level;
  assign full  = (r_level == LW'(DEPTH));
  assign empty = (r_level == '0);
  assign dout  = empty ? '0 : r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/uart_tx_queue.sv
// +----------------------------------------------------------------------+
// | uart_tx_queue: buffered UART transmit queue with sticky overflow and  |
// | IO status word. Rev 1.0                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_tx_queue
  import uart_txq_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input wire logic        clk,
  input wire logic        resetn,
  uart_tx_queue_if.slave  bus
);

  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_idle;
  logic [LW-1:0] w_level;
  logic [7:0]    w_dout;
  logic          r_overflow;

  assign w_pop  = !w_empty & bus.tx_ready;
  assign w_push = bus.wr_valid & (!w_full | w_pop);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (w_push),
    .pop    (w_pop),
    .flush  (bus.flush),
    .din    (bus.wr_data),
    .dout   (w_dout),
    .level  (w_level),
    .full   (w_full),
    .empty  (w_empty)
  );

  // Sticky until flush: a write arrived while full and nothing left
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_overflow <= 1'b0;
    end else if (bus.flush) begin
      r_overflow <= 1'b0;
    end else if (bus.wr_valid && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  assign w_idle       = w_empty & bus.tx_ready;

  assign bus.tx_valid = !w_empty;
  assign bus.tx_data  = w_dout;
  assign bus.full     = w_full;
  assign bus.level    = w_level;
  assign bus.overflow = r_overflow;
  assign bus.status   = make_status(w_full, w_idle, r_overflow);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_queue.sv
// +----------------------------------------------------------------------+
// | tb_uart_tx_queue: directed scenarios plus random traffic against a    |
// | queue-based reference model. Rev 1.0                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_uart_tx_queue;

  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  uart_tx_queue_if #(.DEPTH(DEPTH), .LW(LW)) bus ();

  uart_tx_queue #(.DEPTH(DEPTH), .LW(LW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0] m_q[$];
  bit         m_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [31:0] exp_stat;
    bit          exp_full;
    bit          exp_idle;
    exp_full = (m_q.size() == DEPTH);
    exp_idle = (m_q.size() == 0) && bus.tx_ready;
    exp_stat = 32'(m_ovf) << 11 | 32'(exp_idle) << 10 | 32'(exp_full) << 9;
    chk("tx_valid", 32'(bus.tx_valid), 32'(m_q.size() != 0));
    chk("tx_data",  32'(bus.tx_data),  (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
    chk("level",    32'(bus.level),    32'(m_q.size()));
    chk("full",     32'(bus.full),     32'(exp_full));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("status",   bus.status,        exp_stat);
  endtask

  task automatic model_advance(input bit wr, input logic [7:0] d, input bit rdy, input bit fl);
    bit popped;
    if (fl) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      popped = (m_q.size() != 0) && rdy;
      if (popped) void'(m_q.pop_front());
      if (wr) begin
        if (m_q.size() < DEPTH) m_q.push_back(d);
        else                    m_ovf = 1'b1;
      end
    end
  endtask

  // Drive one cycle's inputs, check the pre-edge state, then advance the model
  task automatic step(input bit wr, input logic [7:0] d, input bit rdy, input bit fl);
    @(negedge clk);
    bus.wr_valid = wr;
    bus.wr_data  = d;
    bus.tx_ready = rdy;
    bus.flush    = fl;
    #1;
    check_all();
    model_advance(wr, d, rdy, fl);
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_data  = 8'h00;
    bus.tx_ready = 1'b0;
    bus.flush    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
    chk("rst_level",    32'(bus.level),    32'h0);
    chk("rst_status",   bus.status,        32'h0);
    @(negedge clk);
    resetn = 1'b1;

    // Two bytes queued while the emitter is busy, then drained
    step(1, 8'h48, 0, 0);
    step(1, 8'h69, 0, 0);
    step(0, 8'h00, 0, 0);
    chk("hi_level", 32'(bus.level),   32'd2);
    chk("hi_head",  32'(bus.tx_data), 32'h48);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);
    chk("hi_idle", 32'(bus.status[10]), 32'h1);

    // Fill, overflow, drain
    for (int i = 0; i < DEPTH; i++) step(1, 8'(i), 0, 0);
    step(0, 8'h00, 0, 0);
    chk("fill_full",   32'(bus.full), 32'h1);
    chk("fill_status", bus.status,    32'h200);
    step(1, 8'hAA, 0, 0);
    step(0, 8'h00, 0, 0);
    chk("ovf_flag",   32'(bus.overflow), 32'h1);
    chk("ovf_status", bus.status,        32'hA00);
    for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 1);

    // Full queue with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) step(1, 8'(i), 0, 0);
    step(1, 8'hBB, 1, 0);
    step(0, 8'h00, 0, 0);
    chk("fp_level", 32'(bus.level),    32'd16);
    chk("fp_ovf",   32'(bus.overflow), 32'h0);
    for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1, 0);

    // Empty-queue latency: no bypass from wr_valid to tx_valid
    step(1, 8'h55, 1, 0);
    step(0, 8'h00, 1, 0);
    chk("lat_data", 32'(bus.tx_data), 32'h55);
    step(0, 8'h00, 1, 0);
    chk("lat_level", 32'(bus.level), 32'h0);

    // Flush beats a concurrent write and clears overflow
    for (int i = 0; i < DEPTH; i++) step(1, 8'(8'h30 + i), 0, 0);
    step(1, 8'hEE, 0, 0);
    for (int i = 0; i < DEPTH - 5; i++) step(0, 8'h00, 1, 0);
    step(1, 8'hCC, 1, 1);
    step(0, 8'h00, 0, 0);
    chk("fl_level", 32'(bus.level),    32'h0);
    chk("fl_ovf",   32'(bus.overflow), 32'h0);
    step(0, 8'h00, 0, 0);

    // Asynchronous reset between edges
    for (int i = 0; i < 3; i++) step(1, 8'(8'h70 + i), 0, 0);
    @(posedge clk);
    #1;
    bus.wr_valid = 1'b0;
    #1;
    resetn = 1'b0;
    #1;
    chk("ar_tx_valid", 32'(bus.tx_valid), 32'h0);
    chk("ar_tx_data",  32'(bus.tx_data),  32'h0);
    chk("ar_level",    32'(bus.level),    32'h0);
    chk("ar_status",   bus.status,        32'h0);
    #1;
    resetn = 1'b1;
    m_q.delete();
    m_ovf = 1'b0;
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      step(bit'($urandom_range(0, 99) < 60), 8'($urandom),
           bit'($urandom_range(0, 99) < 45), bit'($urandom_range(0, 99) < 2));
    end
    step(0, 8'h00, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_queue.md
# uart_tx_queue

Buffered transmit controller between the CPU's memory-mapped IO page and the UART emitter. CPU byte writes to the UART data word are queued in a small FIFO. The block drives the emitter's valid/ready handshake, so the processor never stalls on a busy transmitter unless the queue is full. It also produces the UART status word returned on IO reads, keeping bit 9 as the "do not write now" flag.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..256.
- LW, $clog2(DEPTH)+1, width of `level`.

Ports:
- clk  in  1  system clock (single clock domain).
- resetn  in  1  reset, asynchronous assert, active-low.
- wr_valid  in  1  one-cycle CPU write strobe to the UART data word (isIO & wstrb & wordaddr bit 1).
- wr_data  in  8  byte to send (mem_wdata[7:0]).
- flush  in  1  synchronous queue discard; also clears overflow.
- tx_valid  out  1  head byte available to emitter.
- tx_data  out  8  head byte.
- tx_ready  in  1  emitter can accept; transfer when tx_valid & tx_ready.
- full  out  1  queue full.
- level  out  LW  occupied entries, 0..DEPTH.
- overflow  out  1  sticky: a write was dropped.
- status  out  32  IO read word: bit 9 = full, bit 10 = idle, bit 11 = overflow, all other bits 0.

## Operation
- Outputs at reset: tx_valid=0, tx_data=0, full=0, level=0, overflow=0, status=0. Pointers are also 0.
- push = wr_valid & (!full | pop). pop = tx_valid & tx_ready.
- Circular buffer with rd_ptr and wr_ptr, each log2(DEPTH) bits, wrapping modulo DEPTH. level is a separate LW-bit counter.
- level update: push only → +1; pop only → −1; both → unchanged. It never exceeds DEPTH and never underflows.
- Full with a simultaneous pop: the push is accepted. The freed slot is reused in the same cycle.
- Full with no pop: wr_valid drops the byte. overflow is set to 1 and stays set until flush or reset.
- Empty with wr_valid: the byte is written. tx_valid rises the next cycle; there is no bypass.
- tx_valid = (level != 0). tx_data = mem[rd_ptr], presented while tx_valid=1 and held stable until pop.
- idle = (level == 0) & tx_ready. Firmware polls idle before a power-down or a LED/UART ordering point.
- flush has priority over push and pop in the same cycle. It sets pointers, level and overflow to 0. The byte on tx_data is abandoned, even if tx_ready was high.
- resetn asserted mid-transfer clears the queue immediately, without waiting for a clock edge.

## Timing
- Write at cycle N (wr_valid high at edge N) → level, full and tx_valid updated after edge N, visible in cycle N+1.
- Pop at edge M → the next head is on tx_data in cycle M+1.
- Sustained throughput is one byte per cycle when tx_ready is held high.
- full, level, overflow and status are all registered-state derived. status is combinational from them plus tx_ready.
- No combinational path from wr_valid to tx_valid. tx_ready affects only idle and pop.

## Structure
- Package uart_txq_pkg holds the status bit positions (STAT_FULL_BIT=9, STAT_IDLE_BIT=10, STAT_OVF_BIT=11) and the default DEPTH. The SOC IO decode and the firmware header use these same constants.
- One natural sub-module: sync_fifo. It is a generic width/depth circular buffer with push, pop, flush, level and full/empty outputs.
- uart_tx_queue wraps sync_fifo and adds:
  - the push-on-full-with-pop rule;
  - overflow tracking;
  - status word assembly.

## Test plan
- Reset, then write 0x48, 0x69 with tx_ready=0:
  - level=2, tx_valid=1, tx_data=0x48;
  - after raising tx_ready, 0x48 then 0x69 pop on consecutive cycles, then level=0 and idle (bit 10) = 1.
- Fill DEPTH=16 with 0x00..0x0F, tx_ready=0:
  - full=1 and status=0x200;
  - a 17th write of 0xAA is dropped, overflow=1, status=0xA00;
  - draining yields exactly 0x00..0x0F.
- Full queue, wr_valid=0xBB and tx_ready=1 in the same cycle:
  - 0x00 pops, 0xBB is accepted, level stays 16, overflow stays 0;
  - 0xBB appears last in drain order.
- Write 0x55 at cycle N with tx_ready=1:
  - tx_valid=0 in cycle N and tx_valid=1 with tx_data=0x55 in N+1;
  - pop at edge N+1, so level=0 in cycle N+2.
- Queue with 5 bytes, overflow=1: flush plus a simultaneous wr_valid=0xCC → level=0, overflow=0, tx_valid=0, and 0xCC is not stored.
- Queue with 3 bytes: pulse resetn low between edges → all outputs go to 0 before the next edge, and remain 0 after release until a new write.
